pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Sequencer for the 5-stage MIPS pipeline (PC/NPC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Drives PC/NPC/IF-ID load enables and the ID control-mux select (S: 1 = NOP bubble).
//  Also drives ALU-operand forwarding selects and supervises power-up hold, load-use
//  stalls and an external halt/drain handshake. Sits beside system_control.
// PARAMETERS
//  INIT_CYCLES  4   cycles the pipeline is held frozen after reset release (>=1)
//  DRAIN_CYCLES 3   cycles needed to empty ID/EX, EX/MEM, MEM/WB on halt (>=1)
//  CNT_W        16  width of the saturating stall counter
// PORTS
//  clk          in  1      rising-edge clock
//  reset        in  1      asynchronous, active-low reset
//  id_rs        in  5      rs field of the instruction in IF/ID
//  id_rt        in  5      rt field of the instruction in IF/ID
//  id_use_rs    in  1      instruction in ID reads rs
//  id_use_rt    in  1      instruction in ID reads rt
//  ex_rd        in  5      destination register in ID/EX
//  ex_rf_en     in  1      ID/EX writes the register file
//  ex_load      in  1      ID/EX is a load (LBU/LW)
//  mem_rd       in  5      destination register in EX/MEM
//  mem_rf_en    in  1      EX/MEM writes the register file
//  wb_rd        in  5      destination register in MEM/WB
//  wb_rf_en     in  1      MEM/WB writes the register file
//  halt_req     in  1      level request to halt and drain the pipeline
//  pc_ld        out 1      PC and NPC load enable
//  if_id_ld     out 1      IF/ID register load enable
//  id_nop       out 1      ID control mux select S (1 = inject zero control word)
//  fwd_a_sel    out 2      operand A source: 00 RF, 01 EX, 10 MEM, 11 WB
//  fwd_b_sel    out 2      operand B source: same encoding as fwd_a_sel
//  halt_ack     out 1      pipeline drained and frozen
//  stall_cnt    out CNT_W  load-use stall cycles since reset, saturating
// BEHAVIOUR
//  FSM states: INIT, RUN, DRAIN, HALTED. Reset to INIT; cnt=0; stall_cnt=0.
//  INIT:
//   - Outputs pc_ld=0, if_id_ld=0, id_nop=1, halt_ack=0.
//   - After INIT_CYCLES clocks, go to RUN, ignoring halt_req.
//  RUN:
//   - Default outputs pc_ld=1, if_id_ld=1, id_nop=0.
//   - hz = ex_load & ex_rf_en & ex_rd!=0 &
//     ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
//   - hz=1 (combinational, same cycle): pc_ld=0, if_id_ld=0, id_nop=1, and
//     stall_cnt+=1, saturating at all-ones.
//   - halt_req=1: go to DRAIN, cnt=0. If hz is also 1, that cycle still shows
//     stall outputs and the stall is counted.
//  DRAIN:
//   - Outputs pc_ld=0, if_id_ld=0, id_nop=1. No hz evaluation; no stall counts.
//   - After DRAIN_CYCLES clocks, go to HALTED. halt_req dropping mid-drain does
//     not abort the drain.
//  HALTED:
//   - Same freeze outputs, halt_ack=1 (registered, Moore).
//   - halt_req=0: go to RUN next edge; halt_ack=0 in that RUN cycle.
//   - The instruction held in IF/ID issues on return to RUN.
//  Forwarding (combinational, all states):
//   - A: ex match first, then mem, then wb, else 00. Match = rf_en & rd!=0 & rd==id_rs.
//   - B: identical, using id_rt. Register 0 is never forwarded.
//  Reset assertion mid-operation forces INIT immediately (async); counters clear.
//  In INIT, DRAIN and HALTED: pc_ld=0, if_id_ld=0, id_nop=1.
// TESTING
//  1. Release reset: pc_ld=0, id_nop=1 for 4 cycles, then pc_ld=1, id_nop=0.
//  2. ex_load=1, ex_rf_en=1, ex_rd=5, id_rs=5, id_use_rs=1 for 1 cycle ->
//     pc_ld=0, if_id_ld=0, id_nop=1 for that cycle; stall_cnt=1.
//  3. ex_rd=mem_rd=wb_rd=8, all rf_en=1, id_rs=id_rt=8 -> fwd_a_sel=fwd_b_sel=01.
//     Set ex_rf_en=0 -> both 10. Set all rd=0 -> both 00.
//  4. halt_req=1 in RUN -> 3 frozen cycles, halt_ack=1 on the 4th.
//     Drop halt_req -> RUN next cycle, halt_ack=0.
//  5. halt_req and load-use hazard in the same cycle -> stall_cnt+1, then DRAIN.
//     Reset low in DRAIN -> INIT, stall_cnt=0.
//  6. Force CNT_W=2, hold hazard for 5 cycles -> stall_cnt stays at 3.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer for the 5-stage MIPS core: power-up hold, load-use stalls,
// halt/drain handshake and ALU operand forwarding selects.
module pipeline_hazard_controller #(
  parameter int unsigned INIT_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_en,
  input  logic             ex_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rf_en,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rf_en,
  input  logic             halt_req,
  output logic             pc_ld,
  output logic             if_id_ld,
  output logic             id_nop,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MAXC = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            hz;
  logic            stall_inc;

  // Youngest producer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] e_rd, input logic e_en,
    input logic [4:0] m_rd, input logic m_en,
    input logic [4:0] w_rd, input logic w_en
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (e_en && e_rd != 5'd0 && e_rd == src)      sel = 2'b01;
    else if (m_en && m_rd != 5'd0 && m_rd == src) sel = 2'b10;
    else if (w_en && w_rd != 5'd0 && w_rd == src) sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_sel(id_rs, ex_rd, ex_rf_en, mem_rd, mem_rf_en, wb_rd, wb_rf_en);
    fwd_b_sel = fwd_sel(id_rt, ex_rd, ex_rf_en, mem_rd, mem_rf_en, wb_rd, wb_rf_en);
    hz = ex_load && ex_rf_en && (ex_rd != 5'd0) &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_ld     = 1'b0;
    if_id_ld  = 1'b0;
    id_nop    = 1'b1;
    halt_ack  = 1'b0;
    stall_inc = 1'b0;
    case (state)
      S_INIT: begin
        if (cnt == INIT_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (hz) begin
          stall_inc = 1'b1;
        end else begin
          pc_ld    = 1'b1;
          if_id_ld = 1'b1;
          id_nop   = 1'b0;
        end
        if (halt_req) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = S_HALTED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_HALTED: begin
        halt_ack = 1'b1;
        if (!halt_req) state_nxt = S_RUN;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_INIT;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller; a second instance
// with a 2-bit stall counter covers saturation.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs, id_use_rt, ex_rf_en, ex_load, mem_rf_en, wb_rf_en, halt_req;

  logic        pc_ld, if_id_ld, id_nop, halt_ack;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  logic        pc_ld2, if_id_ld2, id_nop2, halt_ack2;
  logic [1:0]  fwd_a_sel2, fwd_b_sel2;
  logic [1:0]  stall_cnt2;

  int checks = 0;
  int passes = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.INIT_CYCLES(4), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_rf_en(ex_rf_en),
    .ex_load(ex_load), .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd),
    .wb_rf_en(wb_rf_en), .halt_req(halt_req), .pc_ld(pc_ld), .if_id_ld(if_id_ld),
    .id_nop(id_nop), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .halt_ack(halt_ack), .stall_cnt(stall_cnt)
  );

  pipeline_hazard_controller #(.INIT_CYCLES(4), .DRAIN_CYCLES(3), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_rf_en(ex_rf_en),
    .ex_load(ex_load), .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd),
    .wb_rf_en(wb_rf_en), .halt_req(halt_req), .pc_ld(pc_ld2), .if_id_ld(if_id_ld2),
    .id_nop(id_nop2), .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2),
    .halt_ack(halt_ack2), .stall_cnt(stall_cnt2)
  );

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = '0; ex_rf_en = 1'b0; ex_load = 1'b0;
    mem_rd = '0; mem_rf_en = 1'b0; wb_rd = '0; wb_rf_en = 1'b0;
  endtask

  task automatic set_hazard();
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
  endtask

  // Control outputs packed {pc_ld, if_id_ld, id_nop, halt_ack}.
  task automatic test_reset();
    reset = 1'b0; halt_req = 1'b0; clear_inputs();
    #12;
    checks++;
    if ({pc_ld, if_id_ld, id_nop, halt_ack} !== 4'b0010)
      $display("FAIL reset_ctrl got=%b exp=%b", {pc_ld, if_id_ld, id_nop, halt_ack}, 4'b0010);
    else passes++;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
    else passes++;
  endtask

  // Release reset at a negedge, expect 4 frozen cycles then RUN.
  task automatic release_and_init(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({pc_ld, if_id_ld, id_nop, halt_ack} !== 4'b0010)
        $display("FAIL %s_init_%0d got=%b exp=%b", tag, i, {pc_ld, if_id_ld, id_nop, halt_ack}, 4'b0010);
      else passes++;
      @(negedge clk);
    end
    #1;
    checks++;
    if ({pc_ld, if_id_ld, id_nop, halt_ack} !== 4'b1100)
      $display("FAIL %s_run got=%b exp=%b", tag, {pc_ld, if_id_ld, id_nop, halt_ack}, 4'b1100);
    else passes++;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_hazard();
    #1;
    checks++;
    if ({pc_ld, if_id_ld, id_nop} !== 3'b001)
      $display("FAIL stall_rs got=%b exp=%b", {pc_ld, if_id_ld, id_nop}, 3'b001);
    else passes++;
    exp_stall++;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt !== 16'(exp_stall)) $display("FAIL stall_cnt_1 got=%0d exp=%0d", stall_cnt, exp_stall);
    else passes++;
    checks++;
    if ({pc_ld, if_id_ld, id_nop} !== 3'b110)
      $display("FAIL after_stall got=%b exp=%b", {pc_ld, if_id_ld, id_nop}, 3'b110);
    else passes++;
    // rt operand hazard
    @(negedge clk);
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
    #1;
    checks++;
    if (pc_ld !== 1'b0) $display("FAIL stall_rt got=%b exp=0", pc_ld);
    else passes++;
    exp_stall++;
    // Register 0 destination never stalls
    @(negedge clk);
    clear_inputs();
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    checks++;
    if (pc_ld !== 1'b1) $display("FAIL no_stall_r0 got=%b exp=1", pc_ld);
    else passes++;
    // Matching register but operand unused
    @(negedge clk);
    clear_inputs();
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b0;
    #1;
    checks++;
    if (pc_ld !== 1'b1) $display("FAIL no_stall_unused got=%b exp=1", pc_ld);
    else passes++;
    checks++;
    if (stall_cnt !== 16'(exp_stall)) $display("FAIL stall_cnt_2 got=%0d exp=%0d", stall_cnt, exp_stall);
    else passes++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_forwarding();
    ex_rd = 5'd8; mem_rd = 5'd8; wb_rd = 5'd8;
    ex_rf_en = 1'b1; mem_rf_en = 1'b1; wb_rf_en = 1'b1;
    id_rs = 5'd8; id_rt = 5'd8;
    #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) $display("FAIL fwd_ex got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, 4'b0101);
    else passes++;
    ex_rf_en = 1'b0;
    #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) $display("FAIL fwd_mem got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, 4'b1010);
    else passes++;
    mem_rf_en = 1'b0;
    #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1111) $display("FAIL fwd_wb got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, 4'b1111);
    else passes++;
    ex_rf_en = 1'b1; mem_rf_en = 1'b1;
    ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL fwd_r0 got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    else passes++;
    ex_rd = 5'd3; mem_rd = 5'd4; wb_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd4;
    #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0110) $display("FAIL fwd_split got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, 4'b0110);
    else passes++;
    id_rs = 5'd7; id_rt = 5'd12;
    #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1100) $display("FAIL fwd_wb_rf got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, 4'b1100);
    else passes++;
    clear_inputs();
  endtask

  task automatic test_halt();
    @(negedge clk);
    halt_req = 1'b1;
    #1;
    checks++;
    if ({pc_ld, halt_ack} !== 2'b10) $display("FAIL halt_req_run got=%b exp=%b", {pc_ld, halt_ack}, 2'b10);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({pc_ld, if_id_ld, id_nop, halt_ack} !== 4'b0010)
        $display("FAIL drain_%0d got=%b exp=%b", i, {pc_ld, if_id_ld, id_nop, halt_ack}, 4'b0010);
      else passes++;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({pc_ld, if_id_ld, id_nop, halt_ack} !== 4'b0011)
        $display("FAIL halted_%0d got=%b exp=%b", i, {pc_ld, if_id_ld, id_nop, halt_ack}, 4'b0011);
      else passes++;
    end
    halt_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({pc_ld, if_id_ld, id_nop, halt_ack} !== 4'b1100)
      $display("FAIL resume got=%b exp=%b", {pc_ld, if_id_ld, id_nop, halt_ack}, 4'b1100);
    else passes++;
    // One-cycle request: dropping it mid-drain must not abort the drain
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pc_ld, halt_ack} !== 2'b00) $display("FAIL pulse_drain_%0d got=%b exp=%b", i, {pc_ld, halt_ack}, 2'b00);
      else passes++;
      @(negedge clk);
    end
    #1;
    checks++;
    if ({pc_ld, halt_ack} !== 2'b01) $display("FAIL pulse_halted got=%b exp=%b", {pc_ld, halt_ack}, 2'b01);
    else passes++;
    @(negedge clk); #1;
    checks++;
    if ({pc_ld, halt_ack} !== 2'b10) $display("FAIL pulse_resume got=%b exp=%b", {pc_ld, halt_ack}, 2'b10);
    else passes++;
  endtask

  task automatic test_halt_hazard_reset();
    @(negedge clk);
    set_hazard();
    halt_req = 1'b1;
    #1;
    checks++;
    if ({pc_ld, if_id_ld, id_nop} !== 3'b001)
      $display("FAIL halt_hz_stall got=%b exp=%b", {pc_ld, if_id_ld, id_nop}, 3'b001);
    else passes++;
    exp_stall++;
    @(negedge clk); #1;
    checks++;
    if (stall_cnt !== 16'(exp_stall)) $display("FAIL halt_hz_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    else passes++;
    @(negedge clk); #1;
    checks++;
    if ({pc_ld, id_nop, halt_ack, stall_cnt} !== {3'b010, 16'(exp_stall)})
      $display("FAIL drain_no_count got=%b/%0d exp=010/%0d", {pc_ld, id_nop, halt_ack}, stall_cnt, exp_stall);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if ({pc_ld, if_id_ld, id_nop, halt_ack} !== 4'b0010)
      $display("FAIL async_reset_ctrl got=%b exp=%b", {pc_ld, if_id_ld, id_nop, halt_ack}, 4'b0010);
    else passes++;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL async_reset_cnt got=%0d exp=0", stall_cnt);
    else passes++;
    exp_stall = 0;
    halt_req = 1'b0;
    clear_inputs();
  endtask

  task automatic test_saturation();
    release_and_init("sat");
    set_hazard();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (stall_cnt2 !== 2'((i > 3) ? 3 : i))
        $display("FAIL sat_cnt2_%0d got=%0d exp=%0d", i, stall_cnt2, (i > 3) ? 3 : i);
      else passes++;
    end
    checks++;
    if (stall_cnt !== 16'd5) $display("FAIL wide_cnt got=%0d exp=5", stall_cnt);
    else passes++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    release_and_init("boot");
    test_load_use();
    test_forwarding();
    test_halt();
    test_halt_hazard_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
